bounce_sprite_engine: RTL and testbench
=======================================

// Module: bounce_sprite_engine
// PURPOSE
//  Renders NUM_BOXES solid rectangles that bounce independently inside the VGA active area.
//  Sits between the VGA timing generator (pixelx/pixely/vsync) and the colour pins on the 25 MHz pixel clock.
//  Positions advance once per frame, on a vsync edge detected in the clk domain.
//  Per-pixel colour is resolved by fixed priority; box 0 is on top.
// PARAMETERS
//  NUM_BOXES  2          number of independent box channels (1..8)
//  COORD_W    11         width of the pixel coordinates and positions
//  H_ACTIVE   640        visible width in pixels
//  V_ACTIVE   480        visible height in pixels
//  BOX_W      100        box width in pixels (< H_ACTIVE)
//  BOX_H      100        box height in pixels (< V_ACTIVE)
//  STEP       1          pixels moved per frame on each axis (1..BOX_W)
//  X0, Y0     50, 50     reset position of box 0
//  X_SPACING  120        added to X0 per box index at reset
//  Y_SPACING  60         added to Y0 per box index at reset
//  COLORS     {8{3'b100}} packed RGB per box; box i uses COLORS[3*i +: 3]
// PORTS
//  clk        in   1         pixel clock
//  rst        in   1         asynchronous, active-low reset
//  pixelx     in   COORD_W   current pixel column from the timing generator
//  pixely     in   COORD_W   current pixel row from the timing generator
//  vsync      in   1         vsync from the timing generator; a rising edge marks a frame tick
//  enable     in   1         1 = boxes move on frame ticks; 0 = positions frozen
//  r, g, b    out  1 each    pixel colour, registered
//  hit        out  NUM_BOXES per-box coverage of the current pixel, registered
//  frame_tick out  1         single-cycle pulse on a detected vsync rising edge
// BEHAVIOUR
//  Reset (rst=0, takes effect immediately):
//   - r, g, b, hit and frame_tick are 0.
//   - Box i is at (X0+i*X_SPACING, Y0+i*Y_SPACING), clamped to XMAX/YMAX.
//   - X direction is + for even i and - for odd i; Y direction is + for all boxes.
//  Frame tick: vsync is registered into vs_q; frame_tick = vsync & ~vs_q, exactly 1 cycle per rising edge.
//   vsync held high for any length gives one tick. No logic is clocked by vsync.
//  Limits: XMAX = H_ACTIVE-BOX_W, YMAX = V_ACTIVE-BOX_H.
//   Compute in COORD_W+1 bits so that no add or subtract wraps.
//  Per-axis position update, on the cycle after frame_tick, only when enable=1:
//   - Dir +: if pos+STEP >= MAX then pos <= MAX and dir <= -; else pos <= pos+STEP.
//   - Dir -: if pos <= STEP then pos <= 0 and dir <= +; else pos <= pos-STEP.
//   - A box never leaves [0,MAX] and never overshoots a wall; a wall hit takes one frame.
//  Coverage uses half-open bounds: hit_i = (pos_x <= pixelx < pos_x+BOX_W) && (pos_y <= pixely < pos_y+BOX_H).
//   Pixels outside the active area (pixelx >= H_ACTIVE or pixely >= V_ACTIVE) give no hit.
//  Output latency is 1 clk: hit, r, g and b reflect the pixelx/pixely of the previous cycle.
//  Colour: {r,g,b} = COLORS of the lowest-index box with hit set; 3'b000 when no box hits.
//  A position update and a coverage compare may fall in the same cycle.
//   The compare then uses the old position; the update lands in vblank, so the visible frame is consistent.
//  enable=0 during a tick: that tick is lost and is not replayed later.
//  Reset during active video: outputs go to 0 asynchronously.
//   Rendering resumes from the reset positions on the next clk edge after rst=1.
// STRUCTURE
//  Shared package vga_pkg:
//   - coord_t = logic [COORD_W-1:0]
//   - H_ACTIVE / V_ACTIVE defaults
//   - rgb_t = logic [2:0]
//   - dir_t enum {DIR_NEG, DIR_POS}
//  Sub-module bounce_box_channel holds one box: the position/direction registers, the bounce logic and the hit compare.
//   It takes parameters for the initial position and direction.
//   The top generates NUM_BOXES channels, plus the vsync edge detector and the priority colour mux.
// TESTING
//  1. Hold rst=0 mid-frame -> r=g=b=0, hit=0 at once. Release rst -> box0 covers (50,50), not (49,50).
//  2. NUM_BOXES=1, STEP=1, one vsync rising edge -> x=y=51.
//     pixel (51,51) -> hit=1 one cycle later. Pixel (151,51) -> hit=0 (half-open bound).
//  3. Right wall: X0=538, STEP=4 -> tick: x=540, dir -. Next tick: x=536.
//  4. Left wall: box1 at x=2, dir -, STEP=4 -> tick: x=0, dir +. Next tick: x=4.
//  5. Two boxes at the same position, COLORS 3'b100 (box0) and 3'b010 (box1) -> rgb=100, hit=2'b11.
//  6. enable=0 for 3 ticks -> positions unchanged.
//     vsync held high 1000 cycles -> exactly one frame_tick pulse.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA types and defaults used by the sprite engine and its box channels.
package vga_pkg;

  localparam int VGA_COORD_W  = 11;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  typedef logic [VGA_COORD_W-1:0] coord_t;
  typedef logic [2:0]             rgb_t;
  typedef enum logic {DIR_NEG = 1'b0, DIR_POS = 1'b1} dir_t;

  // Reset positions past the wall are pulled back onto the wall.
  function automatic int clamp_pos(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/bounce_sprite_engine_if.sv
// Pixel stream from the timing generator in, colour/coverage out.
interface bounce_sprite_engine_if #(
  parameter int NUM_BOXES = 2,
  parameter int COORD_W   = 11
);
  logic [COORD_W-1:0]   pixelx;
  logic [COORD_W-1:0]   pixely;
  logic                 vsync;
  logic                 enable;
  logic                 r;
  logic                 g;
  logic                 b;
  logic [NUM_BOXES-1:0] hit;
  logic                 frame_tick;

  modport master (output pixelx, pixely, vsync, enable,
                  input  r, g, b, hit, frame_tick);
  modport slave  (input  pixelx, pixely, vsync, enable,
                  output r, g, b, hit, frame_tick);
endinterface

// File: rtl/bounce_box_channel.sv
// One bouncing box: position/direction state, wall bounce, and pixel coverage.
module bounce_box_channel import vga_pkg::*; #(
  parameter int   COORD_W    = VGA_COORD_W,
  parameter int   H_ACTIVE   = VGA_H_ACTIVE,
  parameter int   V_ACTIVE   = VGA_V_ACTIVE,
  parameter int   BOX_W      = 100,
  parameter int   BOX_H      = 100,
  parameter int   STEP       = 1,
  parameter int   INIT_X     = 0,
  parameter int   INIT_Y     = 0,
  parameter dir_t INIT_DIR_X = DIR_POS,
  parameter dir_t INIT_DIR_Y = DIR_POS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] pixelx,
  input  logic [COORD_W-1:0] pixely,
  input  logic               move,
  output logic               hit
);

  // One extra bit everywhere so pos+STEP and pos+BOX_W never wrap.
  localparam logic [COORD_W:0]   XMAX  = (COORD_W+1)'(H_ACTIVE - BOX_W);
  localparam logic [COORD_W:0]   YMAX  = (COORD_W+1)'(V_ACTIVE - BOX_H);
  localparam logic [COORD_W:0]   STP   = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0]   BW    = (COORD_W+1)'(BOX_W);
  localparam logic [COORD_W:0]   BH    = (COORD_W+1)'(BOX_H);
  localparam logic [COORD_W:0]   HA    = (COORD_W+1)'(H_ACTIVE);
  localparam logic [COORD_W:0]   VA    = (COORD_W+1)'(V_ACTIVE);
  localparam logic [COORD_W-1:0] IX    = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] IY    = COORD_W'(INIT_Y);

  logic [COORD_W-1:0] pos_x, pos_y;
  dir_t               dir_x, dir_y;
  logic [COORD_W:0]   nx_x, nx_y;
  dir_t               nd_x, nd_y;
  logic [COORD_W:0]   px, py, bx, by;

  // Single-axis bounce: land exactly on the wall and turn around in the same frame.
  function automatic void axis_step(input  logic [COORD_W:0] p,
                                    input  dir_t             d,
                                    input  logic [COORD_W:0] mx,
                                    output logic [COORD_W:0] np,
                                    output dir_t             nd);
    np = p;
    nd = d;
    if (d == DIR_POS) begin
      if (p + STP >= mx) begin
        np = mx;
        nd = DIR_NEG;
      end else begin
        np = p + STP;
      end
    end else begin
      if (p <= STP) begin
        np = '0;
        nd = DIR_POS;
      end else begin
        np = p - STP;
      end
    end
  endfunction

  // Next position/direction for both axes.
  always_comb begin
    nx_x = '0;
    nx_y = '0;
    nd_x = dir_x;
    nd_y = dir_y;
    axis_step({1'b0, pos_x}, dir_x, XMAX, nx_x, nd_x);
    axis_step({1'b0, pos_y}, dir_y, YMAX, nx_y, nd_y);
  end

  // Position/direction state advances only on a gated frame tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x <= IX;
      pos_y <= IY;
      dir_x <= INIT_DIR_X;
      dir_y <= INIT_DIR_Y;
    end else if (move) begin
      pos_x <= nx_x[COORD_W-1:0];
      pos_y <= nx_y[COORD_W-1:0];
      dir_x <= nd_x;
      dir_y <= nd_y;
    end
  end

  assign px = {1'b0, pixelx};
  assign py = {1'b0, pixely};
  assign bx = {1'b0, pos_x};
  assign by = {1'b0, pos_y};

  // Half-open coverage, masked to the visible area.
  assign hit = (px >= bx) && (px < bx + BW) && (px < HA) &&
               (py >= by) && (py < by + BH) && (py < VA);

endmodule

// File: rtl/bounce_sprite_engine.sv
// NUM_BOXES bouncing boxes over the VGA active area with fixed-priority colour.
module bounce_sprite_engine import vga_pkg::*; #(
  parameter int                 NUM_BOXES = 2,
  parameter int                 COORD_W   = VGA_COORD_W,
  parameter int                 H_ACTIVE  = VGA_H_ACTIVE,
  parameter int                 V_ACTIVE  = VGA_V_ACTIVE,
  parameter int                 BOX_W     = 100,
  parameter int                 BOX_H     = 100,
  parameter int                 STEP      = 1,
  parameter int                 X0        = 50,
  parameter int                 Y0        = 50,
  parameter int                 X_SPACING = 120,
  parameter int                 Y_SPACING = 60,
  parameter logic [3*8-1:0]     COLORS    = {8{3'b100}}
) (
  input  logic                   clk,
  input  logic                   rst,
  bounce_sprite_engine_if.slave  bus
);

  logic                 vs_q;
  logic                 tick_q;
  logic                 move;
  logic [NUM_BOXES-1:0] hit_c;
  logic [NUM_BOXES-1:0] hit_q;
  rgb_t                 rgb_c;
  rgb_t                 rgb_q;

  // vsync is sampled as data; the registered tick lets the update land one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      vs_q   <= bus.vsync;
      tick_q <= bus.vsync & ~vs_q;
    end
  end

  // A tick seen while disabled is dropped, not queued.
  assign move = tick_q & bus.enable;

  for (genvar i = 0; i < NUM_BOXES; i++) begin : g_box
    localparam int IX = clamp_pos(X0 + i*X_SPACING, H_ACTIVE - BOX_W);
    localparam int IY = clamp_pos(Y0 + i*Y_SPACING, V_ACTIVE - BOX_H);
    localparam dir_t DX = (i % 2 == 0) ? DIR_POS : DIR_NEG;

    bounce_box_channel #(
      .COORD_W    (COORD_W),
      .H_ACTIVE   (H_ACTIVE),
      .V_ACTIVE   (V_ACTIVE),
      .BOX_W      (BOX_W),
      .BOX_H      (BOX_H),
      .STEP       (STEP),
      .INIT_X     (IX),
      .INIT_Y     (IY),
      .INIT_DIR_X (DX),
      .INIT_DIR_Y (DIR_POS)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .pixelx (bus.pixelx),
      .pixely (bus.pixely),
      .move   (move),
      .hit    (hit_c[i])
    );
  end

  // Lowest-index hitting box wins: scan high to low so low indices overwrite.
  always_comb begin
    rgb_c = 3'b000;
    for (int i = NUM_BOXES-1; i >= 0; i--) begin
      if (hit_c[i]) rgb_c = COLORS[3*i +: 3];
    end
  end

  // One-cycle output register for coverage and colour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q <= '0;
      rgb_q <= 3'b000;
    end else begin
      hit_q <= hit_c;
      rgb_q <= rgb_c;
    end
  end

  assign bus.hit        = hit_q;
  assign bus.r          = rgb_q[2];
  assign bus.g          = rgb_q[1];
  assign bus.b          = rgb_q[0];
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// Directed bench: three engine configurations probed with hand-computed pixels.
module tb_bounce_sprite_engine;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   ta_cnt;
  int   cnt0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A: defaults, two boxes at (50,50) dir +x and (170,110) dir -x.
  bounce_sprite_engine_if #(.NUM_BOXES(2), .COORD_W(11)) ia();
  bounce_sprite_engine #(.NUM_BOXES(2)) u_a (.clk(clk), .rst(rst), .bus(ia));

  // B: single box near the right wall, STEP 4.
  bounce_sprite_engine_if #(.NUM_BOXES(1), .COORD_W(11)) ib();
  bounce_sprite_engine #(.NUM_BOXES(1), .X0(538), .Y0(50), .STEP(4)) u_b (.clk(clk), .rst(rst), .bus(ib));

  // C: two stacked boxes at (2,0); box1 heads for the left wall. Colours 100 / 010.
  bounce_sprite_engine_if #(.NUM_BOXES(2), .COORD_W(11)) ic();
  bounce_sprite_engine #(.NUM_BOXES(2), .X0(2), .Y0(0), .X_SPACING(0), .Y_SPACING(0),
                         .STEP(4), .COLORS({18'd0, 3'b010, 3'b100})) u_c (.clk(clk), .rst(rst), .bus(ic));

  always @(negedge clk) if (ia.frame_tick) ta_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic probe_a(input int x, input int y, input logic [1:0] eh, input logic [2:0] ec, input string tag);
    ia.pixelx = 11'(x);
    ia.pixely = 11'(y);
    @(posedge clk); #1;
    chk({tag, "_hit"}, 32'(ia.hit), 32'(eh));
    chk({tag, "_rgb"}, 32'({ia.r, ia.g, ia.b}), 32'(ec));
  endtask

  task automatic probe_b(input int x, input int y, input logic eh, input string tag);
    ib.pixelx = 11'(x);
    ib.pixely = 11'(y);
    @(posedge clk); #1;
    chk({tag, "_hit"}, 32'(ib.hit), 32'(eh));
    chk({tag, "_rgb"}, 32'({ib.r, ib.g, ib.b}), eh ? 32'h4 : 32'h0);
  endtask

  task automatic probe_c(input int x, input int y, input logic [1:0] eh, input logic [2:0] ec, input string tag);
    ic.pixelx = 11'(x);
    ic.pixely = 11'(y);
    @(posedge clk); #1;
    chk({tag, "_hit"}, 32'(ic.hit), 32'(eh));
    chk({tag, "_rgb"}, 32'({ic.r, ic.g, ic.b}), 32'(ec));
  endtask

  task automatic tick_a();
    ia.vsync = 1'b1;
    repeat (4) @(posedge clk); #1;
    ia.vsync = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic tick_b();
    ib.vsync = 1'b1;
    repeat (4) @(posedge clk); #1;
    ib.vsync = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic tick_c();
    ic.vsync = 1'b1;
    repeat (4) @(posedge clk); #1;
    ic.vsync = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; ta_cnt = 0;
    rst = 1'b0;
    ia.pixelx = '0; ia.pixely = '0; ia.vsync = 1'b0; ia.enable = 1'b1;
    ib.pixelx = '0; ib.pixely = '0; ib.vsync = 1'b0; ib.enable = 1'b1;
    ic.pixelx = '0; ic.pixely = '0; ic.vsync = 1'b0; ic.enable = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk); #1;
    chk("rst_hit",  32'(ia.hit), 32'h0);
    chk("rst_rgb",  32'({ia.r, ia.g, ia.b}), 32'h0);
    chk("rst_tick", 32'(ia.frame_tick), 32'h0);
    rst = 1'b1;

    // Reset in the middle of a covered pixel clears outputs without a clock edge.
    probe_a(60, 60, 2'b01, 3'b100, "pre_rst");
    #3 rst = 1'b0;
    #1;
    chk("async_rst_hit", 32'(ia.hit), 32'h0);
    chk("async_rst_rgb", 32'({ia.r, ia.g, ia.b}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset positions.
    probe_a(50, 50,   2'b01, 3'b100, "a0_origin");
    probe_a(49, 50,   2'b00, 3'b000, "a0_left");
    probe_a(170, 110, 2'b10, 3'b100, "a1_origin");
    probe_a(169, 110, 2'b00, 3'b000, "a1_left");

    // One tick: box0 -> (51,51), box1 -> (169,111).
    tick_a();
    probe_a(51, 51,   2'b01, 3'b100, "a0_t1");
    probe_a(50, 51,   2'b00, 3'b000, "a0_t1_xlo");
    probe_a(51, 50,   2'b00, 3'b000, "a0_t1_ylo");
    probe_a(150, 51,  2'b01, 3'b100, "a0_t1_xin");
    probe_a(151, 51,  2'b00, 3'b000, "a0_t1_xhi");
    probe_a(51, 150,  2'b01, 3'b100, "a0_t1_yin");
    probe_a(51, 151,  2'b00, 3'b000, "a0_t1_yhi");
    probe_a(169, 111, 2'b10, 3'b100, "a1_t1");
    probe_a(168, 111, 2'b00, 3'b000, "a1_t1_xlo");

    // Disabled ticks are lost.
    ia.enable = 1'b0;
    tick_a(); tick_a(); tick_a();
    probe_a(51, 51,  2'b01, 3'b100, "dis_in");
    probe_a(50, 51,  2'b00, 3'b000, "dis_xlo");
    probe_a(151, 51, 2'b00, 3'b000, "dis_xhi");
    probe_a(51, 50,  2'b00, 3'b000, "dis_ylo");
    ia.enable = 1'b1;

    // Long vsync high: exactly one tick, one step.
    cnt0 = ta_cnt;
    ia.vsync = 1'b1;
    repeat (1000) @(posedge clk); #1;
    ia.vsync = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("long_vsync_ticks", 32'(ta_cnt - cnt0), 32'd1);
    probe_a(52, 52,  2'b01, 3'b100, "a0_t2");
    probe_a(51, 52,  2'b00, 3'b000, "a0_t2_xlo");
    probe_a(52, 51,  2'b00, 3'b000, "a0_t2_ylo");
    probe_a(168, 112, 2'b10, 3'b100, "a1_t2");

    // Right wall: 538 -> 540 (turn) -> 536.
    probe_b(538, 50, 1'b1, "b_origin");
    probe_b(537, 50, 1'b0, "b_origin_lo");
    tick_b();
    probe_b(540, 54, 1'b1, "b_t1");
    probe_b(539, 54, 1'b0, "b_t1_lo");
    probe_b(639, 153, 1'b1, "b_t1_corner");
    probe_b(640, 54, 1'b0, "b_t1_offscreen");
    tick_b();
    probe_b(536, 58, 1'b1, "b_t2");
    probe_b(535, 58, 1'b0, "b_t2_lo");
    probe_b(635, 58, 1'b1, "b_t2_hi_in");
    probe_b(636, 58, 1'b0, "b_t2_hi_out");

    // Overlap priority and left wall: box1 2 -> 0 (turn) -> 4; box0 2 -> 6 -> 10.
    probe_c(2, 0,   2'b11, 3'b100, "c_overlap");
    probe_c(1, 0,   2'b00, 3'b000, "c_none");
    probe_c(101, 0, 2'b11, 3'b100, "c_overlap_hi");
    probe_c(102, 0, 2'b00, 3'b000, "c_none_hi");
    tick_c();
    probe_c(0, 4,   2'b10, 3'b010, "c_t1_b1wall");
    probe_c(5, 4,   2'b10, 3'b010, "c_t1_b1only");
    probe_c(6, 4,   2'b11, 3'b100, "c_t1_both");
    probe_c(0, 3,   2'b00, 3'b000, "c_t1_ylo");
    probe_c(100, 4, 2'b01, 3'b100, "c_t1_b0only");
    probe_c(106, 4, 2'b00, 3'b000, "c_t1_past");
    tick_c();
    probe_c(3, 8,   2'b00, 3'b000, "c_t2_none");
    probe_c(4, 8,   2'b10, 3'b010, "c_t2_b1");
    probe_c(10, 8,  2'b11, 3'b100, "c_t2_both");
    probe_c(104, 8, 2'b01, 3'b100, "c_t2_b0");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
